rename: RTL and testbench
=========================

RENAME -- requirements
Module: rename

Interface
REQ-001 Parameter NUM_PREG, default 128, number of physical registers (7-bit tags).
REQ-002 Parameter NUM_AREG, default 32, number of architectural registers.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 valid_in  input  1  decoded instruction valid.
REQ-006 data_in  input  decode_data  decoded instruction: pc, Opcode, fu, rd, rs1, rs2, imm, func3, func7.
REQ-007 ready_in  output  1  rename can accept data_in this cycle.
REQ-008 valid_out  output  1  data_out valid toward dispatch.
REQ-009 data_out  output  rename_data  renamed instruction: decode fields plus ps1, ps2, pd_new, pd_old, rob_tag.
REQ-010 ready_out  input  1  dispatch accepts data_out.
REQ-011 rob_tail_in  input  5  ROB index to be assigned to the next accepted instruction.
REQ-012 commit_valid  input  1  ROB retired an instruction.
REQ-013 commit_pd_old  input  7  old physical tag released by the retiring instruction.
REQ-014 br_resolve_valid  input  1  branch/JALR resolved without mispredict.
REQ-015 br_resolve_tag  input  5  ROB tag of the resolved branch.
REQ-016 mispredict  input  1  branch mispredicted.
REQ-017 mispredict_tag  input  5  ROB tag of the mispredicted branch.

Function
REQ-018 Output stage SHALL be a single register; load when (!valid_out || ready_out) and accept is true; valid_out SHALL clear when ready_out && !accept.
REQ-019 accept = valid_in && ready_in; ready_in = (!valid_out || ready_out) && !(writes_rd && fl_empty) && !(is_br && ckpt_valid) && !mispredict.
REQ-020 writes_rd = rd != 0 && Opcode not in {0100011 store, 1100011 branch}; is_br = Opcode in {1100011, 1100111}.
REQ-021 On accept: ps1 = map[rs1], ps2 = map[rs2], rob_tag = rob_tail_in; map reads SHALL be taken before this cycle's map update.
REQ-022 If writes_rd: pd_new = free-list head entry, pd_old = map[rd], map[rd] <= pd_new, head advances by one; otherwise pd_new = 0 and pd_old = 0.
REQ-023 map[0] SHALL always read 0 and never be written.
REQ-024 Free list: circular FIFO, NUM_PREG entries, 7-bit head/tail pointers wrapping modulo NUM_PREG, 8-bit count; fl_empty = (count == 0).
REQ-025 commit_valid && commit_pd_old != 0 SHALL push commit_pd_old at tail; a same-cycle push and pop SHALL leave count unchanged.
REQ-026 On accepting is_br: set ckpt_valid, save the post-update map, the post-pop head pointer and rob_tail_in as ckpt_tag.
REQ-027 br_resolve_valid && ckpt_valid && br_resolve_tag == ckpt_tag SHALL clear ckpt_valid.
REQ-028 mispredict && ckpt_valid && mispredict_tag == ckpt_tag: next cycle map = ckpt map, head = ckpt head, count = count + ((head - ckpt_head) mod NUM_PREG) + commit push, valid_out = 0, ckpt_valid = 0.
REQ-029 mispredict with a non-matching tag or with !ckpt_valid SHALL only flush valid_out; map and free list remain unchanged.
REQ-030 A commit push in the mispredict cycle SHALL still be applied.
REQ-031 data_out SHALL hold stable while valid_out && !ready_out.

Reset
REQ-032 On reset: map[i] = i for i in 0..31; free list = p32..p127 in ascending order, head = 0, tail = 96, count = 96; ckpt_valid = 0; valid_out = 0; data_out = 0.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight output and checkpoint immediately (asynchronously).

Structure
REQ-034 decode_data, rename_data, opcode constants and NUM_PREG/NUM_AREG SHALL live in types_pkg.
REQ-035 The free list SHALL be the sub-module free_list (push, pop, head-restore, count); map table and checkpoint SHALL be in rename.

Verification
REQ-036 After reset, rename add x5: pd_new = 32, pd_old = 5; next instruction reading x5 gets ps1 = 32.
REQ-037 Hold ready_out = 0 with valid_out = 1: data_out stable, ready_in = 0, no free-list pop.
REQ-038 Rename 96 writers with no commits: the 97th writer gets ready_in = 0; store accepted (ready_in = 1) with pd_new = 0.
REQ-039 Branch at tag 3 (head = 10), then writers to x1 and x2 (head = 12), then mispredict_tag = 3 with commit_pd_old = 7: map[x1], map[x2] restored, head = 10, count increases by 3, valid_out = 0.
REQ-040 Second branch while ckpt_valid: ready_in = 0 until br_resolve_tag matches, then accepted next cycle.
REQ-041 Push/pop wrap: after 200 alternating commit/rename cycles, pointers wrap past 127 and count stays 96 throughout.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the rename slice: decoded/renamed instruction records,
// RV32 opcode constants, register-file sizing and opcode classification helpers.
package types_pkg;

  localparam int NUM_PREG = 128;
  localparam int NUM_AREG = 32;
  localparam int PTAG_W   = 7;
  localparam int AREG_W   = 5;
  localparam int ROB_W    = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {FU_ALU, FU_BRU, FU_LSU, FU_MUL} fu_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [6:0]        opcode;
    fu_e               fu;
    logic [AREG_W-1:0] rd;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [31:0]       imm;
    logic [2:0]        func3;
    logic [6:0]        func7;
  } decode_data;

  typedef struct packed {
    decode_data        dec;
    logic [PTAG_W-1:0] ps1;
    logic [PTAG_W-1:0] ps2;
    logic [PTAG_W-1:0] pd_new;
    logic [PTAG_W-1:0] pd_old;
    logic [ROB_W-1:0]  rob_tag;
  } rename_data;

  // Stores and conditional branches carry an rd field that is really imm bits.
  function automatic logic writes_rd(input decode_data d);
    return (d.rd != '0) && (d.opcode != OP_STORE) && (d.opcode != OP_BRANCH);
  endfunction

  // Instructions that can mispredict and therefore need a map checkpoint.
  function automatic logic is_br(input decode_data d);
    return (d.opcode == OP_BRANCH) || (d.opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags.
//   pop/head_tag   : allocate the head entry; head_next is the post-pop head
//   push/push_tag  : return a tag at the tail
//   restore        : rewind head to restore_head, reclaiming the squashed pops
// Reset contents: tags NUM_ARCH..DEPTH-1 ascending, head 0, tail/count DEPTH-NUM_ARCH.
module free_list import types_pkg::*; #(
  parameter  int DEPTH    = types_pkg::NUM_PREG,
  parameter  int NUM_ARCH = types_pkg::NUM_AREG,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pop,
  output logic [PTAG_W-1:0] head_tag,
  output logic [PTR_W-1:0]  head_next,
  output logic              empty,
  input  logic              push,
  input  logic [PTAG_W-1:0] push_tag,
  input  logic              restore,
  input  logic [PTR_W-1:0]  restore_head
);

  logic [PTAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, cnt_nxt, rel;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_tag  = mem[head];
  assign head_next = pop ? inc(head) : head;
  assign empty     = (count == '0);

  // Entries popped since the checkpoint, modulo DEPTH.
  always_comb begin
    if (head >= restore_head) rel = CNT_W'(head) - CNT_W'(restore_head);
    else                      rel = CNT_W'(DEPTH) + CNT_W'(head) - CNT_W'(restore_head);
  end

  always_comb begin
    cnt_nxt = count;
    if (restore)          cnt_nxt = count + rel + CNT_W'(push);
    else if (push && !pop) cnt_nxt = count + CNT_W'(1);
    else if (pop && !push) cnt_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= PTR_W'(DEPTH - NUM_ARCH);
      count <= CNT_W'(DEPTH - NUM_ARCH);
    end else begin
      count <= cnt_nxt;
      if (restore)  head <= restore_head;
      else if (pop) head <= inc(head);
      if (push)     tail <= inc(tail);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < DEPTH - NUM_ARCH) ? PTAG_W'(i + NUM_ARCH) : '0;
    end else if (push) begin
      mem[tail] <= push_tag;
    end
  end

endmodule

// File: rtl/rename.sv
// Register rename stage: map table lookup, free-list allocation, single
// branch checkpoint with mispredict recovery, one-entry output register.
//   valid_in/data_in/ready_in    : decoded instruction in
//   valid_out/data_out/ready_out : renamed instruction toward dispatch
//   rob_tail_in                  : ROB slot given to the accepted instruction
//   commit_*                     : retiring instruction frees its old tag
//   br_resolve_*, mispredict*    : branch outcome from execute
module rename import types_pkg::*; #(
  parameter int NUM_PREG = types_pkg::NUM_PREG,
  parameter int NUM_AREG = types_pkg::NUM_AREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  decode_data        data_in,
  output logic              ready_in,
  output logic              valid_out,
  output rename_data        data_out,
  input  logic              ready_out,
  input  logic [ROB_W-1:0]  rob_tail_in,
  input  logic              commit_valid,
  input  logic [PTAG_W-1:0] commit_pd_old,
  input  logic              br_resolve_valid,
  input  logic [ROB_W-1:0]  br_resolve_tag,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag
);

  localparam int PTR_W = $clog2(NUM_PREG);
  typedef logic [NUM_AREG-1:0][PTAG_W-1:0] map_t;

  map_t              map, map_upd, ckpt_map;
  logic              ckpt_valid;
  logic [PTR_W-1:0]  ckpt_head, head_next;
  logic [ROB_W-1:0]  ckpt_tag;
  logic              wr, br, accept, fl_empty, mp_hit, push;
  logic [PTAG_W-1:0] fl_tag, ps1, ps2, pd_new, pd_old;
  rename_data        nxt;

  assign wr     = writes_rd(data_in);
  assign br     = is_br(data_in);
  // Any mispredict blocks intake so a restore never coincides with a pop.
  assign ready_in = (!valid_out || ready_out) && !(wr && fl_empty) &&
                    !(br && ckpt_valid) && !mispredict;
  assign accept = valid_in && ready_in;
  assign mp_hit = mispredict && ckpt_valid && (mispredict_tag == ckpt_tag);
  assign push   = commit_valid && (commit_pd_old != '0);

  // Reads see the map as of the start of the cycle; x0 is hardwired to p0.
  assign ps1    = (data_in.rs1 == '0) ? '0 : map[data_in.rs1];
  assign ps2    = (data_in.rs2 == '0) ? '0 : map[data_in.rs2];
  assign pd_new = wr ? fl_tag : '0;
  assign pd_old = wr ? map[data_in.rd] : '0;

  always_comb begin
    map_upd = map;
    if (accept && wr) map_upd[data_in.rd] = pd_new;
  end

  always_comb begin
    nxt         = '0;
    nxt.dec     = data_in;
    nxt.ps1     = ps1;
    nxt.ps2     = ps2;
    nxt.pd_new  = pd_new;
    nxt.pd_old  = pd_old;
    nxt.rob_tag = rob_tail_in;
  end

  free_list #(.DEPTH(NUM_PREG), .NUM_ARCH(NUM_AREG)) u_fl (
    .clk          (clk),
    .reset        (reset),
    .pop          (accept && wr),
    .head_tag     (fl_tag),
    .head_next    (head_next),
    .empty        (fl_empty),
    .push         (push),
    .push_tag     (commit_pd_old),
    .restore      (mp_hit),
    .restore_head (ckpt_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) map[i] <= PTAG_W'(i);
    end else begin
      map <= mp_hit ? ckpt_map : map_upd;
    end
  end

  // Checkpoint holds the map including the branch's own rd write (JALR),
  // so recovery keeps the link register allocation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckpt_valid <= 1'b0;
      ckpt_map   <= '0;
      ckpt_head  <= '0;
      ckpt_tag   <= '0;
    end else if (mp_hit) begin
      ckpt_valid <= 1'b0;
    end else if (accept && br) begin
      ckpt_valid <= 1'b1;
      ckpt_map   <= map_upd;
      ckpt_head  <= head_next;
      ckpt_tag   <= rob_tail_in;
    end else if (br_resolve_valid && ckpt_valid && (br_resolve_tag == ckpt_tag)) begin
      ckpt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (mispredict) begin
      valid_out <= 1'b0;
    end else if (accept) begin
      valid_out <= 1'b1;
      data_out  <= nxt;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename.sv
module tb_rename;
  import types_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid_in, ready_in, valid_out, ready_out;
  decode_data       data_in;
  rename_data       data_out;
  logic [ROB_W-1:0] rob_tail_in, br_resolve_tag, mispredict_tag;
  logic             commit_valid, br_resolve_valid, mispredict;
  logic [6:0]       commit_pd_old;
  logic [31:0]      pc = 32'h1000;
  int               checks = 0;
  int               errors = 0;

  rename dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .ready_out(ready_out), .rob_tail_in(rob_tail_in),
    .commit_valid(commit_valid), .commit_pd_old(commit_pd_old),
    .br_resolve_valid(br_resolve_valid), .br_resolve_tag(br_resolve_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insn(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2);
    data_in        = '0;
    data_in.pc     = pc;
    data_in.opcode = op;
    data_in.fu     = FU_ALU;
    data_in.rd     = rd;
    data_in.rs1    = rs1;
    data_in.rs2    = rs2;
    pc             = pc + 32'd4;
    valid_in       = 1'b1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = '0;
    reset    = 1'b1;
    #1;
    reset    = 1'b0;
  endtask

  initial begin
    valid_in = 0; data_in = '0; ready_out = 0; rob_tail_in = '0;
    commit_valid = 0; commit_pd_old = '0; br_resolve_valid = 0; br_resolve_tag = '0;
    mispredict = 0; mispredict_tag = '0;

    // reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_data_out", 32'(data_out.pd_new | data_out.ps1 | data_out.rob_tag), 0);
    chk("rst_count", 32'(dut.u_fl.count), 96);
    chk("rst_head", 32'(dut.u_fl.head), 0);
    chk("rst_tail", 32'(dut.u_fl.tail), 96);
    chk("rst_ready_in", 32'(ready_in), 1);
    tick(); tick();
    reset = 1'b0;

    // basic rename and RAW through the map
    ready_out = 1; rob_tail_in = 0;
    insn(OP_REG, 5, 1, 2);
    #1 chk("add_ready_in", 32'(ready_in), 1);
    tick();
    chk("add_valid", 32'(valid_out), 1);
    chk("add_pd_new", 32'(data_out.pd_new), 32);
    chk("add_pd_old", 32'(data_out.pd_old), 5);
    chk("add_ps1", 32'(data_out.ps1), 1);
    chk("add_ps2", 32'(data_out.ps2), 2);
    chk("add_count", 32'(dut.u_fl.count), 95);
    rob_tail_in = 1;
    insn(OP_REG, 6, 5, 5);
    tick();
    chk("raw_ps1", 32'(data_out.ps1), 32);
    chk("raw_ps2", 32'(data_out.ps2), 32);
    chk("raw_pd_new", 32'(data_out.pd_new), 33);
    chk("raw_rob_tag", 32'(data_out.rob_tag), 1);

    // backpressure: output holds, no pop
    ready_out = 0; rob_tail_in = 2;
    insn(OP_REG, 7, 0, 5);
    #1 chk("stall_ready_in", 32'(ready_in), 0);
    tick(); tick();
    chk("stall_valid", 32'(valid_out), 1);
    chk("stall_pd_new", 32'(data_out.pd_new), 33);
    chk("stall_rob_tag", 32'(data_out.rob_tag), 1);
    chk("stall_count", 32'(dut.u_fl.count), 94);
    ready_out = 1;
    #1 chk("unstall_ready_in", 32'(ready_in), 1);
    tick();
    chk("unstall_pd_new", 32'(data_out.pd_new), 34);
    chk("unstall_pd_old", 32'(data_out.pd_old), 7);
    chk("unstall_ps1_x0", 32'(data_out.ps1), 0);
    chk("unstall_ps2", 32'(data_out.ps2), 32);
    rob_tail_in = 3;
    insn(OP_REG, 0, 6, 0);
    tick();
    chk("x0_pd_new", 32'(data_out.pd_new), 0);
    chk("x0_pd_old", 32'(data_out.pd_old), 0);
    chk("x0_ps1", 32'(data_out.ps1), 33);
    chk("x0_count", 32'(dut.u_fl.count), 93);
    valid_in = 0;
    tick();
    chk("drain_valid", 32'(valid_out), 0);

    // branch checkpoint and mispredict recovery
    do_reset();
    for (int i = 0; i < 10; i++) begin
      insn(OP_IMM, 5'(10 + i), 0, 0);
      tick();
    end
    chk("pre_br_head", 32'(dut.u_fl.head), 10);
    rob_tail_in = 3;
    insn(OP_BRANCH, 0, 10, 11);
    #1 chk("br_ready_in", 32'(ready_in), 1);
    tick();
    chk("br_ckpt_valid", 32'(dut.ckpt_valid), 1);
    chk("br_ps1", 32'(data_out.ps1), 32);
    chk("br_pd_new", 32'(data_out.pd_new), 0);
    rob_tail_in = 4;
    insn(OP_REG, 1, 0, 0);
    tick();
    chk("spec_x1_pd_new", 32'(data_out.pd_new), 42);
    rob_tail_in = 5;
    insn(OP_REG, 2, 1, 0);
    tick();
    chk("spec_x2_pd_new", 32'(data_out.pd_new), 43);
    chk("spec_x2_ps1", 32'(data_out.ps1), 42);
    chk("spec_head", 32'(dut.u_fl.head), 12);
    chk("spec_count", 32'(dut.u_fl.count), 84);
    rob_tail_in = 4;
    insn(OP_REG, 3, 1, 2);
    mispredict = 1; mispredict_tag = 3; commit_valid = 1; commit_pd_old = 7;
    #1 chk("mp_ready_in", 32'(ready_in), 0);
    tick();
    mispredict = 0; commit_valid = 0;
    chk("mp_valid_out", 32'(valid_out), 0);
    chk("mp_head", 32'(dut.u_fl.head), 10);
    chk("mp_count", 32'(dut.u_fl.count), 87);
    chk("mp_tail", 32'(dut.u_fl.tail), 97);
    chk("mp_ckpt_valid", 32'(dut.ckpt_valid), 0);
    #1 chk("post_mp_ready_in", 32'(ready_in), 1);
    tick();
    chk("post_mp_ps1", 32'(data_out.ps1), 1);
    chk("post_mp_ps2", 32'(data_out.ps2), 2);
    chk("post_mp_pd_new", 32'(data_out.pd_new), 42);
    chk("post_mp_pd_old", 32'(data_out.pd_old), 3);

    // second branch blocked until the first resolves
    rob_tail_in = 6;
    insn(OP_BRANCH, 0, 3, 0);
    tick();
    chk("brA_ps1", 32'(data_out.ps1), 42);
    rob_tail_in = 7;
    insn(OP_JALR, 1, 0, 0);
    br_resolve_valid = 1; br_resolve_tag = 9;
    #1 chk("brB_blocked", 32'(ready_in), 0);
    tick();
    br_resolve_tag = 6;
    #1 chk("brB_blocked_resolve_cycle", 32'(ready_in), 0);
    tick();
    br_resolve_valid = 0;
    #1 chk("brB_ready", 32'(ready_in), 1);
    tick();
    chk("brB_rob_tag", 32'(data_out.rob_tag), 7);
    chk("brB_pd_new", 32'(data_out.pd_new), 43);
    chk("brB_pd_old", 32'(data_out.pd_old), 1);
    chk("brB_ckpt_valid", 32'(dut.ckpt_valid), 1);
    valid_in = 0;
    mispredict = 1; mispredict_tag = 9;
    tick();
    mispredict = 0;
    chk("mp_miss_valid_out", 32'(valid_out), 0);
    chk("mp_miss_head", 32'(dut.u_fl.head), 12);
    chk("mp_miss_count", 32'(dut.u_fl.count), 85);
    chk("mp_miss_ckpt", 32'(dut.ckpt_valid), 1);

    // asynchronous reset mid-operation
    rob_tail_in = 8;
    insn(OP_REG, 4, 0, 0);
    tick();
    chk("pre_arst_valid", 32'(valid_out), 1);
    valid_in = 0;
    reset = 1;
    #1;
    chk("arst_valid_out", 32'(valid_out), 0);
    chk("arst_ckpt_valid", 32'(dut.ckpt_valid), 0);
    chk("arst_count", 32'(dut.u_fl.count), 96);
    #1 reset = 0;

    // exhaust the free list
    for (int i = 0; i < 96; i++) begin
      rob_tail_in = 5'(i);
      insn(OP_IMM, 5'(1 + (i % 31)), 0, 0);
      tick();
    end
    chk("full_last_pd_new", 32'(data_out.pd_new), 127);
    chk("full_count", 32'(dut.u_fl.count), 0);
    insn(OP_REG, 9, 0, 0);
    #1 chk("empty_writer_ready", 32'(ready_in), 0);
    tick();
    chk("empty_writer_valid", 32'(valid_out), 0);
    insn(OP_STORE, 5, 1, 2);
    #1 chk("empty_store_ready", 32'(ready_in), 1);
    tick();
    chk("empty_store_valid", 32'(valid_out), 1);
    chk("empty_store_pd_new", 32'(data_out.pd_new), 0);
    chk("empty_store_pd_old", 32'(data_out.pd_old), 0);

    // push/pop wrap with steady occupancy
    do_reset();
    for (int i = 0; i < 200; i++) begin
      rob_tail_in = 5'(i);
      insn(OP_REG, 5'(1 + (i % 31)), 0, 0);
      commit_valid = 1;
      commit_pd_old = 7'((i % 127) + 1);
      tick();
      chk("wrap_count", 32'(dut.u_fl.count), 96);
    end
    commit_valid = 0; valid_in = 0;
    chk("wrap_head", 32'(dut.u_fl.head), 72);
    chk("wrap_tail", 32'(dut.u_fl.tail), 40);
    chk("wrap_pd_new", 32'(data_out.pd_new), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
